reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 117 +++++++++++
 tb/tb_reg_scoreboard.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Dual-issue register scoreboard: 2-bit pending-write counters for r1..r31 with issue stalls.
// Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle write-back of the last pending write unblock a read.
module reg_scoreboard (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        way0_issueValid_i,
  input  logic [4:0]  way0_rs1Addr_i,
  input  logic [4:0]  way0_rs2Addr_i,
  input  logic        way0_rs1ReadEnable_i,
  input  logic        way0_rs2ReadEnable_i,
  input  logic [4:0]  way0_rdAddr_i,
  input  logic        way0_rdWriteEnable_i,
  input  logic        way1_issueValid_i,
  input  logic [4:0]  way1_rs1Addr_i,
  input  logic [4:0]  way1_rs2Addr_i,
  input  logic        way1_rs1ReadEnable_i,
  input  logic        way1_rs2ReadEnable_i,
  input  logic [4:0]  way1_rdAddr_i,
  input  logic        way1_rdWriteEnable_i,
  input  logic        wb0_valid_i,
  input  logic [4:0]  wb0_rdAddr_i,
  input  logic        wb1_valid_i,
  input  logic [4:0]  wb1_rdAddr_i,
  input  logic        flush_i,
  output logic        way0_stall_o,
  output logic        way1_stall_o,
  output logic [31:0] busy_o,
  output logic        err_o
);

  logic [1:0]  r_cnt [1:31];
  logic        r_err;
  logic [1:0]  w_cnt_d [1:31];
  logic [31:0] w_busy, w_full, w_ge2, w_wb0_hit, w_wb1_hit, w_src_busy, w_uflow;
  logic        w_wr0, w_wr1, w_haz0, w_haz1, w_stall0, w_stall1, w_iss0, w_iss1;
  logic        w_raw01, w_ovf01;

  always_comb begin
    w_busy     = '0;
    w_full     = '0;
    w_ge2      = '0;
    w_wb0_hit  = '0;
    w_wb1_hit  = '0;
    w_src_busy = '0;
    for (int r = 1; r < 32; r++) begin
      w_busy[r]    = (r_cnt[r] != 2'd0);
      w_full[r]    = (r_cnt[r] == 2'd3);
      w_ge2[r]     = r_cnt[r][1];
      w_wb0_hit[r] = wb0_valid_i && (wb0_rdAddr_i == 5'(r));
      w_wb1_hit[r] = wb1_valid_i && (wb1_rdAddr_i == 5'(r));
`ifdef SCOREBOARD_BYPASS_EN
      w_src_busy[r] = w_busy[r] &&
                      !((r_cnt[r] == 2'd1) && (w_wb0_hit[r] || w_wb1_hit[r]));
`else
      w_src_busy[r] = w_busy[r];
`endif
    end
  end

  // Stalls use only pre-update counters; during reset they follow flush_i alone.
  always_comb begin
    w_wr0   = way0_rdWriteEnable_i && (way0_rdAddr_i != 5'd0);
    w_wr1   = way1_rdWriteEnable_i && (way1_rdAddr_i != 5'd0);
    w_haz0  = (way0_rs1ReadEnable_i && w_src_busy[way0_rs1Addr_i]) ||
              (way0_rs2ReadEnable_i && w_src_busy[way0_rs2Addr_i]) ||
              (w_wr0 && w_full[way0_rdAddr_i]);
    w_haz1  = (way1_rs1ReadEnable_i && w_src_busy[way1_rs1Addr_i]) ||
              (way1_rs2ReadEnable_i && w_src_busy[way1_rs2Addr_i]) ||
              (w_wr1 && w_full[way1_rdAddr_i]);
    w_stall0 = flush_i || (reset_n && w_haz0);
    w_iss0   = way0_issueValid_i && !w_stall0;
    w_raw01  = w_iss0 && w_wr0 &&
               ((way1_rs1ReadEnable_i && (way1_rs1Addr_i == way0_rdAddr_i)) ||
                (way1_rs2ReadEnable_i && (way1_rs2Addr_i == way0_rdAddr_i)));
    w_ovf01  = w_iss0 && w_wr0 && w_wr1 && (way1_rdAddr_i == way0_rdAddr_i) &&
               w_ge2[way0_rdAddr_i];
    w_stall1 = flush_i || (reset_n && (w_haz1 || w_stall0 || w_raw01 || w_ovf01));
    w_iss1   = way1_issueValid_i && !w_stall1;
  end

  always_comb begin
    w_uflow = '0;
    for (int r = 1; r < 32; r++) begin
      logic [2:0] w_inc;
      logic [2:0] w_dec;
      logic [2:0] w_sum;
      w_inc = 3'(w_iss0 && w_wr0 && (way0_rdAddr_i == 5'(r))) +
              3'(w_iss1 && w_wr1 && (way1_rdAddr_i == 5'(r)));
      w_dec = 3'(w_wb0_hit[r]) + 3'(w_wb1_hit[r]);
      w_sum = {1'b0, r_cnt[r]} + w_inc;
      if (w_sum < w_dec) begin
        w_cnt_d[r] = 2'd0;
        w_uflow[r] = 1'b1;
      end else begin
        w_cnt_d[r] = 2'(w_sum - w_dec);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 1; r < 32; r++) r_cnt[r] <= 2'd0;
      r_err <= 1'b0;
    end else if (flush_i) begin
      for (int r = 1; r < 32; r++) r_cnt[r] <= 2'd0;
    end else begin
      for (int r = 1; r < 32; r++) r_cnt[r] <= w_cnt_d[r];
      r_err <= r_err | (|w_uflow);
    end
  end

  assign way0_stall_o = w_stall0;
  assign way1_stall_o = w_stall1;
  assign busy_o       = w_busy;
  assign err_o        = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: driver pushes expected outputs, a negedge monitor compares.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        way0_issueValid_i, way0_rs1ReadEnable_i, way0_rs2ReadEnable_i, way0_rdWriteEnable_i;
  logic [4:0]  way0_rs1Addr_i, way0_rs2Addr_i, way0_rdAddr_i;
  logic        way1_issueValid_i, way1_rs1ReadEnable_i, way1_rs2ReadEnable_i, way1_rdWriteEnable_i;
  logic [4:0]  way1_rs1Addr_i, way1_rs2Addr_i, way1_rdAddr_i;
  logic        wb0_valid_i, wb1_valid_i, flush_i;
  logic [4:0]  wb0_rdAddr_i, wb1_rdAddr_i;
  logic        way0_stall_o, way1_stall_o, err_o;
  logic [31:0] busy_o;

`ifdef SCOREBOARD_BYPASS_EN
  localparam logic Byp = 1'b1;
`else
  localparam logic Byp = 1'b0;
`endif

  typedef struct packed {
    logic        s0;
    logic        s1;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  exp_t  q_exp[$];
  string q_name[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .way0_issueValid_i    (way0_issueValid_i),
    .way0_rs1Addr_i       (way0_rs1Addr_i),
    .way0_rs2Addr_i       (way0_rs2Addr_i),
    .way0_rs1ReadEnable_i (way0_rs1ReadEnable_i),
    .way0_rs2ReadEnable_i (way0_rs2ReadEnable_i),
    .way0_rdAddr_i        (way0_rdAddr_i),
    .way0_rdWriteEnable_i (way0_rdWriteEnable_i),
    .way1_issueValid_i    (way1_issueValid_i),
    .way1_rs1Addr_i       (way1_rs1Addr_i),
    .way1_rs2Addr_i       (way1_rs2Addr_i),
    .way1_rs1ReadEnable_i (way1_rs1ReadEnable_i),
    .way1_rs2ReadEnable_i (way1_rs2ReadEnable_i),
    .way1_rdAddr_i        (way1_rdAddr_i),
    .way1_rdWriteEnable_i (way1_rdWriteEnable_i),
    .wb0_valid_i          (wb0_valid_i),
    .wb0_rdAddr_i         (wb0_rdAddr_i),
    .wb1_valid_i          (wb1_valid_i),
    .wb1_rdAddr_i         (wb1_rdAddr_i),
    .flush_i              (flush_i),
    .way0_stall_o         (way0_stall_o),
    .way1_stall_o         (way1_stall_o),
    .busy_o               (busy_o),
    .err_o                (err_o)
  );

  // Monitor: everything queued since the last falling edge describes the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (q_exp.size() > 0) begin
        exp_t  e;
        exp_t  g;
        string nm;
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        g  = '{s0: way0_stall_o, s1: way1_stall_o, busy: busy_o, err: err_o};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL %s: got s0=%b s1=%b busy=%h err=%b, want s0=%b s1=%b busy=%h err=%b",
                   nm, g.s0, g.s1, g.busy, g.err, e.s0, e.s1, e.busy, e.err);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    {way0_issueValid_i, way0_rs1ReadEnable_i, way0_rs2ReadEnable_i, way0_rdWriteEnable_i} = '0;
    {way0_rs1Addr_i, way0_rs2Addr_i, way0_rdAddr_i} = '0;
    {way1_issueValid_i, way1_rs1ReadEnable_i, way1_rs2ReadEnable_i, way1_rdWriteEnable_i} = '0;
    {way1_rs1Addr_i, way1_rs2Addr_i, way1_rdAddr_i} = '0;
    {wb0_valid_i, wb1_valid_i, flush_i} = '0;
    {wb0_rdAddr_i, wb1_rdAddr_i} = '0;
  endtask

  task automatic iss0(input logic [4:0] rd, input logic we, input logic [4:0] a1,
                      input logic e1, input logic [4:0] a2, input logic e2);
    way0_issueValid_i = 1'b1;
    way0_rdAddr_i = rd;  way0_rdWriteEnable_i = we;
    way0_rs1Addr_i = a1; way0_rs1ReadEnable_i = e1;
    way0_rs2Addr_i = a2; way0_rs2ReadEnable_i = e2;
  endtask

  task automatic iss1(input logic [4:0] rd, input logic we, input logic [4:0] a1,
                      input logic e1, input logic [4:0] a2, input logic e2);
    way1_issueValid_i = 1'b1;
    way1_rdAddr_i = rd;  way1_rdWriteEnable_i = we;
    way1_rs1Addr_i = a1; way1_rs1ReadEnable_i = e1;
    way1_rs2Addr_i = a2; way1_rs2ReadEnable_i = e2;
  endtask

  task automatic wb0(input logic [4:0] rd);
    wb0_valid_i = 1'b1; wb0_rdAddr_i = rd;
  endtask

  task automatic wb1(input logic [4:0] rd);
    wb1_valid_i = 1'b1; wb1_rdAddr_i = rd;
  endtask

  task automatic chk(input string nm, input logic s0, input logic s1, input logic [31:0] busy,
                     input logic err);
    q_exp.push_back('{s0: s0, s1: s1, busy: busy, err: err});
    q_name.push_back(nm);
  endtask

  initial begin
    nxt(); chk("reset_idle", 0, 0, 32'h0, 0);
    nxt(); flush_i = 1'b1; chk("reset_flush", 1, 1, 32'h0, 0);
    nxt(); iss0(5'd2, 1, 5'd0, 0, 5'd0, 0); iss1(5'd0, 0, 5'd2, 1, 5'd0, 0);
    chk("reset_nohaz", 0, 0, 32'h0, 0);
    nxt(); reset_n = 1'b1; chk("post_reset", 0, 0, 32'h0, 0);

    // RAW on r5 through way0.
    nxt(); iss0(5'd5, 1, 5'd0, 0, 5'd0, 0); chk("issue_r5", 0, 0, 32'h0, 0);
    nxt(); iss0(5'd0, 0, 5'd5, 1, 5'd0, 0); chk("raw_r5", 1, 1, 32'h20, 0);
    nxt(); iss0(5'd0, 0, 5'd5, 1, 5'd0, 0); wb0(5'd5); chk("wb_r5", !Byp, !Byp, 32'h20, 0);
    nxt(); iss0(5'd0, 0, 5'd5, 1, 5'd0, 0); chk("clear_r5", 0, 0, 32'h0, 0);

    // Intra-group RAW on r7.
    nxt(); iss0(5'd7, 1, 5'd0, 0, 5'd0, 0); iss1(5'd0, 0, 5'd0, 0, 5'd7, 1);
    chk("intra_r7", 0, 1, 32'h0, 0);
    nxt(); iss1(5'd0, 0, 5'd0, 0, 5'd7, 1); chk("still_r7", 0, 1, 32'h80, 0);
    nxt(); wb1(5'd7); chk("wb_r7", 0, 0, 32'h80, 0);
    nxt(); iss1(5'd0, 0, 5'd0, 0, 5'd7, 1); chk("clear_r7", 0, 0, 32'h0, 0);

    // Counter saturation on r3.
    nxt(); iss0(5'd3, 1, 5'd0, 0, 5'd0, 0); iss1(5'd3, 1, 5'd0, 0, 5'd0, 0);
    chk("dual_r3", 0, 0, 32'h0, 0);
    nxt(); iss0(5'd3, 1, 5'd0, 0, 5'd0, 0); iss1(5'd3, 1, 5'd0, 0, 5'd0, 0);
    chk("dual_ovf_r3", 0, 1, 32'h8, 0);
    nxt(); iss0(5'd3, 1, 5'd0, 0, 5'd0, 0); wb0(5'd3); chk("full_r3", 1, 1, 32'h8, 0);
    nxt(); iss0(5'd3, 1, 5'd0, 0, 5'd0, 0); chk("release_r3", 0, 0, 32'h8, 0);
    nxt(); wb0(5'd3); wb1(5'd3); chk("dual_wb_r3", 0, 0, 32'h8, 0);
    nxt(); iss0(5'd3, 1, 5'd0, 0, 5'd0, 0); wb0(5'd3); chk("net_r3", 0, 0, 32'h8, 0);
    nxt(); wb1(5'd3); chk("last_wb_r3", 0, 0, 32'h8, 0);
    nxt(); chk("empty_r3", 0, 0, 32'h0, 0);

    // Write-back forwarding on r4.
    nxt(); iss0(5'd4, 1, 5'd0, 0, 5'd0, 0); chk("issue_r4", 0, 0, 32'h0, 0);
    nxt(); iss0(5'd0, 0, 5'd4, 1, 5'd0, 0); wb1(5'd4); chk("bypass_r4", !Byp, !Byp, 32'h10, 0);
    nxt(); chk("clear_r4", 0, 0, 32'h0, 0);

    // Underflow.
    nxt(); wb0(5'd9); chk("uflow_r9", 0, 0, 32'h0, 0);
    nxt(); chk("err_set", 0, 0, 32'h0, 1);
    nxt(); chk("err_sticky", 0, 0, 32'h0, 1);

    // Flush, and r0 never tracked.
    nxt(); iss0(5'd10, 1, 5'd0, 0, 5'd0, 0); iss1(5'd11, 1, 5'd0, 0, 5'd0, 0);
    chk("issue_10_11", 0, 0, 32'h0, 1);
    nxt(); iss0(5'd0, 1, 5'd0, 0, 5'd0, 0); iss1(5'd12, 1, 5'd0, 0, 5'd0, 0);
    chk("issue_r0_12", 0, 0, 32'h0000_0C00, 1);
    nxt(); flush_i = 1'b1; iss0(5'd13, 1, 5'd0, 0, 5'd0, 0); wb0(5'd10);
    chk("flush", 1, 1, 32'h0000_1C00, 1);
    nxt(); iss0(5'd14, 1, 5'd0, 0, 5'd0, 0); chk("post_flush", 0, 0, 32'h0, 1);
    nxt(); chk("busy_r14", 0, 0, 32'h0000_4000, 1);

    // Asynchronous reset: checked before any further rising edge.
    nxt(); reset_n = 1'b0; chk("async_reset", 0, 0, 32'h0, 0);
    nxt(); reset_n = 1'b1; wb0(5'd14); chk("wb_after_reset", 0, 0, 32'h0, 0);
    nxt(); chk("err_after_reset", 0, 0, 32'h0, 1);

    repeat (3) @(posedge clk);
    if (q_exp.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
